// File: rtl/execute_stage_if.sv
// Decode-to-EXE operand bundle, EXE-to-fetch redirect and the EXE/MEM pipeline latch.
// Handshake: an instruction in EXE advances into the MEM latch on a rising edge with EXE_V=1 and EXE_STALL=0; MEM_STALL=1 freezes the latch.
interface execute_stage_if #(
  parameter int XLEN = 64
);
  logic            EXE_V;
  logic [31:0]     EXE_IR;
  logic [XLEN-1:0] EXE_NPC;
  logic [XLEN-1:0] ALU1;
  logic [XLEN-1:0] ALU2;
  logic [XLEN-1:0] TARGET_ADDRESS;
  logic [XLEN-1:0] MEM_ADDRESS;
  logic [XLEN-1:0] EXE_RFD;
  logic [XLEN-1:0] EXE_CSRFD;
  logic            MEM_STALL;
  logic            EXE_STALL;
  logic [4:0]      EXE_DR;
  logic            EXE_FE_BR_V;
  logic [XLEN-1:0] EXE_FE_BR_PC;
  logic            MEM_V;
  logic [31:0]     MEM_IR;
  logic [XLEN-1:0] MEM_NPC;
  logic [XLEN-1:0] MEM_ALU_RESULT;
  logic [XLEN-1:0] MEM_ADDR;
  logic [XLEN-1:0] MEM_ST_DATA;
  logic [XLEN-1:0] MEM_CSR_DATA;
  logic [1:0]      DIV_STATE;

  modport slave (
    input  EXE_V, EXE_IR, EXE_NPC, ALU1, ALU2, TARGET_ADDRESS, MEM_ADDRESS,
           EXE_RFD, EXE_CSRFD, MEM_STALL,
    output EXE_STALL, EXE_DR, EXE_FE_BR_V, EXE_FE_BR_PC, MEM_V, MEM_IR, MEM_NPC,
           MEM_ALU_RESULT, MEM_ADDR, MEM_ST_DATA, MEM_CSR_DATA, DIV_STATE
  );

  modport master (
    output EXE_V, EXE_IR, EXE_NPC, ALU1, ALU2, TARGET_ADDRESS, MEM_ADDRESS,
           EXE_RFD, EXE_CSRFD, MEM_STALL,
    input  EXE_STALL, EXE_DR, EXE_FE_BR_V, EXE_FE_BR_PC, MEM_V, MEM_IR, MEM_NPC,
           MEM_ALU_RESULT, MEM_ADDR, MEM_ST_DATA, MEM_CSR_DATA, DIV_STATE
  );
endinterface

// File: rtl/execute_stage.sv
// RV64IM execute stage: single-cycle ALU/MUL/CSR, iterative radix-2 divider,
// branch resolution and the EXE/MEM pipeline latch.
module execute_stage #(
  parameter int XLEN      = 64,
  parameter int DIV_ITERS = 64
) (
  input logic            CLK,
  input logic            RESET,
  execute_stage_if.slave bus
);
  localparam logic [4:0] OPC_LOAD    = 5'b00000;
  localparam logic [4:0] OPC_OPIMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC   = 5'b00101;
  localparam logic [4:0] OPC_OPIMM32 = 5'b00110;
  localparam logic [4:0] OPC_STORE   = 5'b01000;
  localparam logic [4:0] OPC_OP      = 5'b01100;
  localparam logic [4:0] OPC_LUI     = 5'b01101;
  localparam logic [4:0] OPC_OP32    = 5'b01110;
  localparam logic [4:0] OPC_BRANCH  = 5'b11000;
  localparam logic [4:0] OPC_JALR    = 5'b11001;
  localparam logic [4:0] OPC_JAL     = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM  = 5'b11100;
  localparam int CW = $clog2(DIV_ITERS + 1);

  typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_BUSY = 2'd1, DIV_DONE = 2'd2} div_state_e;

  logic [4:0]      opc;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a, b;
  logic            is_mext, is_div, is_w, is_sub;
  logic            is_branch, is_jal, is_jalr, is_store, is_load, is_csr;
  logic            exe_stall;
  logic            unused_ir;

  assign opc       = bus.EXE_IR[6:2];
  assign funct3    = bus.EXE_IR[14:12];
  assign a         = bus.ALU1;
  assign b         = bus.ALU2;
  assign is_mext   = ((opc == OPC_OP) || (opc == OPC_OP32)) && (bus.EXE_IR[31:25] == 7'b0000001);
  assign is_div    = is_mext & funct3[2];
  assign is_w      = (opc == OPC_OP32) || (opc == OPC_OPIMM32);
  assign is_sub    = bus.EXE_IR[30] & ((opc == OPC_OP) || (opc == OPC_OP32));
  assign is_branch = (opc == OPC_BRANCH);
  assign is_jal    = (opc == OPC_JAL);
  assign is_jalr   = (opc == OPC_JALR);
  assign is_store  = (opc == OPC_STORE);
  assign is_load   = (opc == OPC_LOAD);
  assign is_csr    = (opc == OPC_SYSTEM) && (funct3 != 3'b000);
  assign unused_ir = ^{bus.EXE_IR[24:20], bus.EXE_IR[1:0]};

  // Integer ALU; arithmetic right shifts live in their own signals so the
  // surrounding mux cannot strip their signedness.
  logic [XLEN-1:0] sra64, alu64;
  logic [31:0]     sra32, alu32;

  assign sra64 = $signed(a) >>> b[5:0];
  assign sra32 = $signed(a[31:0]) >>> b[4:0];

  always_comb begin
    alu64 = '0;
    case (funct3)
      3'b000:  alu64 = is_sub ? (a - b) : (a + b);
      3'b001:  alu64 = a << b[5:0];
      3'b010:  alu64 = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011:  alu64 = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100:  alu64 = a ^ b;
      3'b101:  alu64 = bus.EXE_IR[30] ? sra64 : (a >> b[5:0]);
      3'b110:  alu64 = a | b;
      default: alu64 = a & b;
    endcase
  end

  always_comb begin
    alu32 = '0;
    case (funct3)
      3'b000:  alu32 = is_sub ? (a[31:0] - b[31:0]) : (a[31:0] + b[31:0]);
      3'b001:  alu32 = a[31:0] << b[4:0];
      3'b101:  alu32 = bus.EXE_IR[30] ? sra32 : (a[31:0] >> b[4:0]);
      default: alu32 = '0;
    endcase
  end

  // Multiplier: operands extended to 2*XLEN so one product serves all signedness variants.
  logic              mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
  logic [XLEN-1:0]   mul_res;

  assign mul_a_sgn = (funct3[1:0] != 2'b11);
  assign mul_b_sgn = ~funct3[1];
  assign mul_a     = {{XLEN{a[XLEN-1] & mul_a_sgn}}, a};
  assign mul_b     = {{XLEN{b[XLEN-1] & mul_b_sgn}}, b};
  assign mul_p     = mul_a * mul_b;
  assign mul_res   = is_w ? {{(XLEN-32){mul_p[31]}}, mul_p[31:0]}
                   : (funct3[1:0] == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];

  // Divider operand preparation
  logic            div_sgn, dvd_neg, dvs_neg, div_zero, div_ovf;
  logic [XLEN-1:0] dvd, dvs, dvd_mag, dvs_mag;

  assign div_sgn  = ~funct3[0];
  assign dvd      = is_w ? {{(XLEN-32){a[31] & div_sgn}}, a[31:0]} : a;
  assign dvs      = is_w ? {{(XLEN-32){b[31] & div_sgn}}, b[31:0]} : b;
  assign dvd_neg  = div_sgn & dvd[XLEN-1];
  assign dvs_neg  = div_sgn & dvs[XLEN-1];
  assign dvd_mag  = dvd_neg ? (~dvd + 1'b1) : dvd;
  assign dvs_mag  = dvs_neg ? (~dvs + 1'b1) : dvs;
  assign div_zero = (dvs == '0);
  assign div_ovf  = div_sgn && (dvs == '1) &&
                    (is_w ? (dvd == {{(XLEN-32){1'b1}}, 32'h8000_0000})
                          : (dvd == {1'b1, {(XLEN-1){1'b0}}}));

  div_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic            negq_q, negr_q;
  logic [XLEN:0]   rem_sh, rem_sub;
  logic            rem_ge;

  assign rem_sh  = {rem_q, quo_q[XLEN-1]};
  assign rem_sub = rem_sh - {1'b0, dvs_q};
  assign rem_ge  = ~rem_sub[XLEN];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: if (bus.EXE_V && is_div) begin
          negq_q <= 1'b0;
          negr_q <= 1'b0;
          cnt_q  <= '0;
          if (div_zero) begin
            quo_q   <= '1;
            rem_q   <= dvd;
            state_q <= DIV_DONE;
          end else if (div_ovf) begin
            quo_q   <= dvd;
            rem_q   <= '0;
            state_q <= DIV_DONE;
          end else begin
            quo_q   <= dvd_mag;
            rem_q   <= '0;
            dvs_q   <= dvs_mag;
            negq_q  <= dvd_neg ^ dvs_neg;
            negr_q  <= dvd_neg;
            state_q <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          quo_q <= {quo_q[XLEN-2:0], rem_ge};
          rem_q <= rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DIV_ITERS - 1)) state_q <= DIV_DONE;
        end
        DIV_DONE: if (!bus.MEM_STALL) state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

  // Sign fix-up happens on the way out of DONE
  logic [XLEN-1:0] quo_fix, rem_fix, div_sel, div_res;

  assign quo_fix = negq_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = negr_q ? (~rem_q + 1'b1) : rem_q;
  assign div_sel = funct3[1] ? rem_fix : quo_fix;
  assign div_res = is_w ? {{(XLEN-32){div_sel[31]}}, div_sel[31:0]} : div_sel;

  assign exe_stall = bus.MEM_STALL | (bus.EXE_V & is_div & (state_q != DIV_DONE));

  // Result, CSR and branch next values
  logic [XLEN-1:0] result_d, csr_src, csr_data_d, br_pc_d;
  logic            br_taken;

  always_comb begin
    result_d = '0;
    case (opc)
      OPC_OP:      result_d = is_mext ? (funct3[2] ? div_res : mul_res) : alu64;
      OPC_OPIMM:   result_d = alu64;
      OPC_OP32:    result_d = is_mext ? (funct3[2] ? div_res : mul_res)
                                      : {{(XLEN-32){alu32[31]}}, alu32};
      OPC_OPIMM32: result_d = {{(XLEN-32){alu32[31]}}, alu32};
      OPC_LUI, OPC_JAL, OPC_JALR: result_d = a;
      OPC_AUIPC:   result_d = (bus.EXE_NPC - XLEN'(4)) + a;
      OPC_SYSTEM:  result_d = is_csr ? bus.EXE_CSRFD : '0;
      default:     result_d = '0;
    endcase
  end

  assign csr_src = funct3[2] ? {{(XLEN-5){1'b0}}, bus.EXE_IR[19:15]} : bus.EXE_RFD;

  always_comb begin
    csr_data_d = '0;
    if (is_csr) begin
      case (funct3[1:0])
        2'b01:   csr_data_d = csr_src;
        2'b10:   csr_data_d = bus.EXE_CSRFD | csr_src;
        default: csr_data_d = bus.EXE_CSRFD & ~csr_src;
      endcase
    end
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (a == b);
      3'b001:  br_taken = (a != b);
      3'b100:  br_taken = ($signed(a) < $signed(b));
      3'b101:  br_taken = ($signed(a) >= $signed(b));
      3'b110:  br_taken = (a < b);
      3'b111:  br_taken = (a >= b);
      default: br_taken = 1'b0;
    endcase
  end

  assign br_pc_d = is_jalr ? {bus.TARGET_ADDRESS[XLEN-1:1], 1'b0}
                 : (is_jal || (is_branch && br_taken)) ? bus.TARGET_ADDRESS : bus.EXE_NPC;

  logic            advance, is_redirect;
  logic            mem_v_q, br_v_q;
  logic [31:0]     mem_ir_q;
  logic [XLEN-1:0] mem_npc_q, mem_res_q, mem_addr_q, mem_st_q, mem_csr_q, br_pc_q;

  assign advance     = bus.EXE_V & ~exe_stall;
  assign is_redirect = is_branch | is_jal | is_jalr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_v_q    <= 1'b0;
      mem_ir_q   <= '0;
      mem_npc_q  <= '0;
      mem_res_q  <= '0;
      mem_addr_q <= '0;
      mem_st_q   <= '0;
      mem_csr_q  <= '0;
      br_v_q     <= 1'b0;
      br_pc_q    <= '0;
    end else begin
      br_v_q <= advance & is_redirect;
      if (advance && is_redirect) br_pc_q <= br_pc_d;
      if (!bus.MEM_STALL) begin
        mem_v_q    <= advance;
        mem_ir_q   <= bus.EXE_IR;
        mem_npc_q  <= bus.EXE_NPC;
        mem_res_q  <= result_d;
        mem_addr_q <= (is_load || is_store) ? bus.MEM_ADDRESS : '0;
        mem_st_q   <= is_store ? a : '0;
        mem_csr_q  <= csr_data_d;
      end
    end
  end

  assign bus.EXE_STALL      = exe_stall;
  assign bus.EXE_DR         = (bus.EXE_V && !is_store && !is_branch) ? bus.EXE_IR[11:7] : 5'd0;
  assign bus.EXE_FE_BR_V    = br_v_q;
  assign bus.EXE_FE_BR_PC   = br_pc_q;
  assign bus.MEM_V          = mem_v_q;
  assign bus.MEM_IR         = mem_ir_q;
  assign bus.MEM_NPC        = mem_npc_q;
  assign bus.MEM_ALU_RESULT = mem_res_q;
  assign bus.MEM_ADDR       = mem_addr_q;
  assign bus.MEM_ST_DATA    = mem_st_q;
  assign bus.MEM_CSR_DATA   = mem_csr_q;
  assign bus.DIV_STATE      = state_q;
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline stage directly downstream of decode; consumes decode's latched operands (ALU1, ALU2, TARGET_ADDRESS, MEM_ADDRESS, EXE_RFD, EXE_CSRFD) and produces the EXE→MEM pipeline latch.
- Performs integer ALU ops, RV64M multiply, and CSR new-value computation in one cycle; DIV/REM run on an iterative radix-2 divider FSM.
- Resolves branches and jumps back to fetch.

Parameters:
- XLEN, 64, datapath width.
- DIV_ITERS, 64, divider iterations per divide.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- EXE_V  in  1  valid instruction in EXE
- EXE_IR  in  32  instruction
- EXE_NPC  in  64  PC+4 of instruction
- ALU1, ALU2  in  64 each  operands from decode
- TARGET_ADDRESS  in  64  branch/jump target
- MEM_ADDRESS  in  64  load/store address
- EXE_RFD  in  64  rs1 value (CSR source)
- EXE_CSRFD  in  64  old CSR value
- MEM_STALL  in  1  downstream hold
- EXE_STALL  out  1  hold decode/fetch (comb)
- EXE_DR  out  5  rd of valid EXE instr writing a GPR, else 0 (comb)
- EXE_FE_BR_V  out  1  branch/jump resolved (registered pulse)
- EXE_FE_BR_PC  out  64  next fetch PC
- MEM_V  out  1  valid to MEM
- MEM_IR  out  32
- MEM_NPC  out  64
- MEM_ALU_RESULT  out  64  rd writeback value
- MEM_ADDR  out  64  load/store address
- MEM_ST_DATA  out  64  store data (ALU1 for stores)
- MEM_CSR_DATA  out  64  new CSR value

Behaviour:
- Reset: all outputs 0, divider FSM IDLE, counter 0. Reset mid-divide aborts to IDLE; no MEM_V.
- Opcode decode uses EXE_IR[6:2], funct3 = IR[14:12], funct7 = IR[31:25].
- OP/OP-IMM: ADD/SUB (SUB only for OP with IR[30]), SLL/SRL/SRA with shamt ALU2[5:0], SLT, SLTU, XOR, OR, AND.
- OP-32/OP-IMM-32: operate on low 32 bits, shamt ALU2[4:0], result sign-extended from bit 31.
- LUI: result = ALU1. AUIPC: result = (EXE_NPC−4)+ALU1. JAL/JALR: result = ALU1 (link). Store: MEM_ST_DATA = ALU1. Load/store: MEM_ADDR = MEM_ADDRESS.
- MUL/MULH/MULHSU/MULHU/MULW are single-cycle (128-bit product; W form sign-extends low 32).
- DIV/DIVU/REM/REMU, and W forms using low-32 operands sign/zero-extended per funct3, go to the divider.
- Divider FSM IDLE→BUSY→DONE→IDLE:
  - Divisor 0: quotient all-ones, remainder = dividend.
  - Signed overflow (MIN/−1): quotient = dividend, remainder 0.
  - Both special cases go IDLE→DONE directly.
  - Otherwise BUSY runs DIV_ITERS cycles on magnitudes; sign is fixed in DONE.
  - W results are truncated to 32 bits, then sign-extended.
- EXE_STALL = MEM_STALL | (EXE_V & div-op & state≠DONE).
  - Normal divide stalls 65 cycles; special case stalls 1 cycle.
- CSR (opcode 11100, funct3≠0): MEM_ALU_RESULT = EXE_CSRFD.
  - MEM_CSR_DATA: RW = src, RS = old|src, RC = old&~src.
  - src = EXE_RFD, or zero-extended IR[19:15] when funct3[2]=1.
- Branch compare on ALU1/ALU2 per funct3 (BEQ, BNE, BLT, BGE, BLTU, BGEU).
  - Every valid branch/jump sets EXE_FE_BR_V=1 for exactly one cycle after its EXE-advance edge.
  - EXE_FE_BR_PC = TARGET_ADDRESS if taken/JAL, TARGET_ADDRESS with bit0 cleared for JALR, EXE_NPC if not taken.
- Latch advance: on an edge with MEM_STALL=0, MEM_V ← EXE_V & ~EXE_STALL and all MEM_* fields load.
  - MEM_STALL=1: all MEM_* hold; divider keeps iterating; DONE holds until the latch advances, then returns to IDLE.
- EXE_DR is 0 for stores, branches, and when EXE_V=0.

Test Plan:
- ADD ALU1=5, ALU2=−7 (0xFFFF_FFFF_FFFF_FFF9) → MEM_V=1 next edge, MEM_ALU_RESULT=0xFFFF_FFFF_FFFF_FFFE; ADDW 0x7FFF_FFFF+1 → 0xFFFF_FFFF_8000_0000.
- DIV 100/−7 → EXE_STALL high 65 cycles, MEM_ALU_RESULT=−14; REM → 2; DIVU x/0 → 0xFFFF_FFFF_FFFF_FFFF after 1-cycle stall; DIV 0x8000_0000_0000_0000/−1 → 0x8000_0000_0000_0000.
- BNE ALU1=3, ALU2=3, NPC=0x104 → EXE_FE_BR_V pulse with PC=0x104; BLT −1<2, TARGET=0x80 → PC=0x80; JALR TARGET=0x201 → PC=0x200, result=NPC.
- CSRRS old=0xF0, rs1=0x0F → MEM_ALU_RESULT=0xF0, MEM_CSR_DATA=0xFF; CSRRCI zimm=0x10, old=0x1F → 0x0F.
- MEM_STALL held 3 cycles during an ADD → MEM_* unchanged, EXE_STALL=1; release → next instruction latches once, with no duplicate or drop.
- RESET asserted at BUSY iteration 20 → next cycle FSM IDLE, MEM_V=0, EXE_STALL=0.
